// File: rtl/piso_serializer_if.sv
// Handshake bundle for the PISO serializer: word-side valid/ready/data in,
// bit-side valid/ready/out/last plus a busy flag.
// The slave modport is the serializer's view; master is its environment's.
interface piso_serializer_if #(
  parameter int N = 8
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         ser_valid;
  logic         ser_ready;
  logic         ser_out;
  logic         ser_last;
  logic         busy;

  modport master (
    output in_valid, in_data, ser_ready,
    input  in_ready, ser_valid, ser_out, ser_last, busy
  );

  modport slave (
    input  in_valid, in_data, ser_ready,
    output in_ready, ser_valid, ser_out, ser_last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer. Takes an N-bit word on a valid/ready
// handshake and emits it one bit per cycle on a valid/ready serial port,
// MSB-first or LSB-first. A new word may be accepted on the same edge that
// ends the last bit of the current one, so consecutive words stream gap-free.
module piso_serializer #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  piso_serializer_if.slave   bus
);

  localparam int             CW       = $clog2(N);
  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
  localparam int             OUT_BIT  = MSB_FIRST ? N - 1 : 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state_reg;
  logic [N-1:0]  sh_reg;
  logic [N-1:0]  sh_next;
  logic [CW-1:0] cnt_reg;

  logic at_last;
  logic accept;
  logic xfer;

  // The word in flight is on its final bit.
  assign at_last = (state_reg == SHIFT) && (cnt_reg == CNT_LAST);

  // Ready when empty, or when the final bit is leaving this very edge.
  // Held low during reset so a word offered alongside reset is never taken.
  assign bus.in_ready = !rst && ((state_reg == IDLE) || (at_last && bus.ser_ready));

  assign accept = bus.in_valid && bus.in_ready;
  assign xfer   = (state_reg == SHIFT) && bus.ser_ready;

  // One-position shift toward the output end, zero-filled at the far end.
  for (genvar gi = 0; gi < N; gi++) begin : g_shift
    if (MSB_FIRST) begin : g_msb
      if (gi == 0) begin : g_fill
        assign sh_next[gi] = 1'b0;
      end else begin : g_move
        assign sh_next[gi] = sh_reg[gi-1];
      end
    end else begin : g_lsb
      if (gi == N - 1) begin : g_fill
        assign sh_next[gi] = 1'b0;
      end else begin : g_move
        assign sh_next[gi] = sh_reg[gi+1];
      end
    end
  end

  // Control FSM and shift register. A new accept overrides the retirement of
  // the word finishing on the same edge, which keeps the stream contiguous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sh_reg    <= '0;
      cnt_reg   <= '0;
    end else if (accept) begin
      state_reg <= SHIFT;
      sh_reg    <= bus.in_data;
      cnt_reg   <= '0;
    end else if (xfer) begin
      if (cnt_reg != CNT_LAST) begin
        cnt_reg <= cnt_reg + CW'(1);
        sh_reg  <= sh_next;
      end else begin
        state_reg <= IDLE;
      end
    end
  end

  // All serial-side outputs come straight from registered state, so they are
  // stable across a stall; the data bit is forced to 0 whenever idle.
  assign bus.ser_valid = (state_reg == SHIFT);
  assign bus.busy      = (state_reg == SHIFT);
  assign bus.ser_last  = at_last;
  assign bus.ser_out   = (state_reg == SHIFT) && sh_reg[OUT_BIT];

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer. Three instances run side by side:
//   d0: N=4 MSB-first, d1: N=4 LSB-first, d2: N=8 MSB-first.
// The reference model tracks each instance as "word in flight + bits left";
// the expected bit is picked from the word by position, and outputs are
// compared every cycle against directed and randomized traffic.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] iv  = '0;
  logic [2:0] sr  = '0;
  logic [7:0] dat [3];

  logic [2:0] ob_rdy, ob_val, ob_out, ob_last, ob_busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model state per instance.
  int         nn    [3] = '{4, 4, 8};
  bit         msb   [3] = '{1'b1, 1'b0, 1'b1};
  int         rem   [3] = '{0, 0, 0};
  logic [7:0] wd    [3];
  logic [7:0] wq    [3][$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int NN = (gi == 2) ? 8 : 4;
    localparam bit MF = (gi == 1) ? 1'b0 : 1'b1;

    piso_serializer_if #(.N(NN)) bus ();

    assign bus.in_valid  = iv[gi];
    assign bus.in_data   = dat[gi][NN-1:0];
    assign bus.ser_ready = sr[gi];
    assign ob_rdy[gi]    = bus.in_ready;
    assign ob_val[gi]    = bus.ser_valid;
    assign ob_out[gi]    = bus.ser_out;
    assign ob_last[gi]   = bus.ser_last;
    assign ob_busy[gi]   = bus.busy;

    piso_serializer #(.N(NN), .MSB_FIRST(MF)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs,
  // advance the model to what the next rising edge should produce.
  task automatic step(input logic r, input logic [2:0] en, input logic [2:0] rdy,
                      input bit junk_valid);
    bit   exp_busy, exp_bit, exp_last, exp_rdy, acc;
    int   k;
    rst = r;
    for (int i = 0; i < 3; i++) begin
      sr[i] = rdy[i];
      if (junk_valid) begin
        iv[i]  = 1'b1;
        dat[i] = 8'($urandom_range(255));
      end else begin
        iv[i]  = en[i] && (wq[i].size() > 0);
        dat[i] = iv[i] ? wq[i][0] : 8'($urandom_range(255));
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_busy = (rem[i] > 0);
      k        = nn[i] - rem[i];
      exp_bit  = exp_busy ? (msb[i] ? wd[i][nn[i]-1-k] : wd[i][k]) : 1'b0;
      exp_last = (rem[i] == 1);
      exp_rdy  = !r && ((rem[i] == 0) || (rem[i] == 1 && sr[i]));
      check($sformatf("d%0d.in_ready", i),  32'(ob_rdy[i]),  32'(exp_rdy));
      check($sformatf("d%0d.ser_valid", i), 32'(ob_val[i]),  32'(exp_busy));
      check($sformatf("d%0d.ser_out", i),   32'(ob_out[i]),  32'(exp_bit));
      check($sformatf("d%0d.ser_last", i),  32'(ob_last[i]), 32'(exp_last));
      check($sformatf("d%0d.busy", i),      32'(ob_busy[i]), 32'(exp_busy));
      if (r) begin
        rem[i] = 0;
      end else begin
        acc = iv[i] && exp_rdy;
        if (rem[i] > 0 && sr[i]) rem[i]--;
        if (acc) begin
          wd[i]  = dat[i];
          rem[i] = nn[i];
          if (wq[i].size() > 0) void'(wq[i].pop_front());
          $display("t=%0t d%0d accept word %0h", $time, i, dat[i]);
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] rdy;
    logic [2:0] en;
    logic       r;
    for (int i = 0; i < 3; i++) dat[i] = 8'h00;
    @(negedge clk);

    // Reset held two cycles with words offered: reset must win.
    step(1'b1, 3'b000, 3'b111, 1'b1);
    step(1'b1, 3'b000, 3'b111, 1'b1);

    // Idle: nothing offered for 10 cycles, downstream readiness random.
    for (int t = 0; t < 10; t++) step(1'b0, 3'b000, 3'($urandom_range(7)), 1'b0);

    // Back-to-back on d0/d1; d2 stalls 3 cycles on bit 2 and sees a word
    // offered mid-flight that must wait for the end of the current one.
    wq[0].push_back(8'h0C); wq[0].push_back(8'h03);
    wq[1].push_back(8'h0C); wq[1].push_back(8'h03);
    wq[2].push_back(8'hA5);
    for (int t = 0; t < 26; t++) begin
      if (t == 2) wq[2].push_back(8'h3C);
      rdy = {(t >= 3 && t <= 5) ? 1'b0 : 1'b1, 2'b11};
      step(1'b0, 3'b111, rdy, 1'b0);
    end

    // Reset in the middle of a word, then a fresh word afterwards.
    wq[0].push_back(8'h0A); wq[1].push_back(8'h0A); wq[2].push_back(8'h5A);
    for (int t = 0; t < 3; t++) step(1'b0, 3'b111, 3'b111, 1'b0);
    step(1'b1, 3'b000, 3'b111, 1'b0);
    wq[0].push_back(8'h06); wq[1].push_back(8'h06); wq[2].push_back(8'h96);
    for (int t = 0; t < 14; t++) step(1'b0, 3'b111, 3'b111, 1'b0);

    // Randomized traffic with stalls, gaps and occasional resets.
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < 3; i++)
        if (wq[i].size() == 0 && $urandom_range(3) == 0)
          wq[i].push_back(8'($urandom_range(255)));
      r = ($urandom_range(199) == 0);
      en = 3'($urandom_range(7)) | 3'($urandom_range(7));
      for (int i = 0; i < 3; i++) rdy[i] = ($urandom_range(3) != 0);
      step(r, en, rdy, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out serializer. It accepts an N-bit word through a valid/ready handshake and shifts it out one bit per cycle, with a valid/ready handshake on the serial side. It is the transmit-side companion to the team's parallel register and deserializer blocks, and sits between a word-wide datapath and a 1-bit link. It supports back-to-back words with no idle gap and downstream back-pressure.

## Interface
- N, default 8, word width in bits; legal range N >= 2.
- MSB_FIRST, default 1: 1 shifts bit N-1 first; 0 shifts bit 0 first.

- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  N  parallel word, sampled only on accept.
- ser_valid  output  1  ser_out carries a valid bit.
- ser_ready  input  1  downstream accepts the current bit.
- ser_out  output  1  current serial bit.
- ser_last  output  1  current bit is the final bit of its word.
- busy  output  1  a word is in flight (equals ser_valid).

## Operation
- Two states:
  - IDLE: no word held.
  - SHIFT: word held in shift register sh[N-1:0]; bit counter cnt has width $clog2(N).
- Accept occurs when in_valid & in_ready are both high at a posedge.
- in_ready is combinational and high when state==IDLE, or when (state==SHIFT & cnt==N-1 & ser_ready). It is forced low while rst is high.
- On accept:
  - sh <= in_data, cnt <= 0, state <= SHIFT.
  - This overrides the advance of any word currently finishing.
- Bit transfer occurs when ser_valid & ser_ready are both high at a posedge.
  - If cnt < N-1: cnt <= cnt+1, and sh shifts left (MSB_FIRST=1) or right (MSB_FIRST=0), filling with 0.
  - If cnt == N-1 and no accept: state <= IDLE.
- Outputs:
  - ser_out = sh[N-1] (MSB_FIRST=1) or sh[0] (MSB_FIRST=0), gated to 0 in IDLE.
  - ser_valid = busy = (state==SHIFT).
  - ser_last = (state==SHIFT & cnt==N-1).
- ser_ready low: sh, cnt and state hold, so ser_out, ser_valid and ser_last stay stable until the transfer.
- in_valid during SHIFT with cnt < N-1: ignored. in_data is not sampled and in_ready stays low.
- Reset values: state IDLE, sh 0, cnt 0, ser_out 0, ser_valid 0, ser_last 0, busy 0, in_ready 0 during rst and 1 the cycle after.

## Timing
- Latency: a word accepted at edge k presents its first bit from cycle k+1. With ser_ready held high, bit i is on ser_out during cycle k+1+i, and ser_last is high in cycle k+N.
- Throughput: 1 bit per cycle. Back-to-back words are accepted at the edge ending the last bit, and the new first bit appears the next cycle with no gap and ser_valid staying high.
- A ser_ready low cycle stretches the word by exactly one cycle per low cycle. in_ready stays low during the last bit if ser_ready is low.
- Reset mid-word: the word is discarded at the reset edge, with no partial completion. All outputs are 0 the following cycle, and no ser_last is emitted for the aborted word.
- Reset and in_valid asserted together: reset wins and no word is accepted.
- Counter wrap: cnt never exceeds N-1. It reloads to 0 only on accept.

## Test plan
- Reset then single word (N=4, MSB_FIRST=1): rst 2 cycles, in_data=4'b1100 accepted at edge k -> ser_out 1,1,0,0 in cycles k+1..k+4; ser_last only in k+4; busy low from k+5; in_ready high again in k+5.
- LSB-first (N=4, MSB_FIRST=0): 4'b1100 -> ser_out 0,0,1,1; ser_last on the 4th bit.
- Back-to-back (N=4): 4'b1100 then 4'b0011 with in_valid held high -> 8 contiguous bits 1,1,0,0,0,0,1,1; ser_valid never drops; exactly two ser_last pulses; second accept coincides with the first word's ser_last edge.
- Back-pressure (N=8, 8'hA5): drop ser_ready for 3 cycles on bit 2 -> ser_out/ser_last stable during the stall; the stream remains 1,0,1,0,0,1,0,1; the word completes 3 cycles late; in_valid asserted mid-word is not accepted.
- Reset mid-word (N=4, 4'b1010): assert rst after 2 bits -> next cycle ser_valid=0, ser_out=0, cnt=0; a new word 4'b0110 after reset serializes fully and correctly.
- Idle handshake: in_valid low for 10 cycles after reset -> ser_valid=0, ser_out=0, in_ready=1 throughout.
